// File: rtl/csr_drv_pkg.sv
// Shared types for the CSR-bus access driver.
// CSR op/number encodings follow the Ibex core.
package csr_drv_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ,
    CSR_OP_WRITE,
    CSR_OP_SET,
    CSR_OP_CLEAR
  } csr_op_e;

  typedef enum logic [11:0] {
    CSR_MSTATUS  = 12'h300,
    CSR_MTVEC    = 12'h305,
    CSR_MSCRATCH = 12'h340,
    CSR_MEPC     = 12'h341
  } csr_num_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    GAP
  } drv_state_e;

  typedef struct packed {
    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        check;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mask;
    logic        exp_illegal;
  } csr_drv_cmd_t;

  function automatic logic rsp_mismatch(
    input csr_drv_cmd_t cmd,
    input logic [31:0]  rdata,
    input logic         illegal
  );
    logic data_bad;
    data_bad = ((rdata ^ cmd.exp_rdata) & cmd.exp_mask) != 32'd0;
    return cmd.check & (data_bad | (illegal != cmd.exp_illegal));
  endfunction

endpackage

// File: rtl/csr_drv_sat_cnt.sv
// Saturating up-counter used for the command
// and error tallies; holds at all-ones.
module csr_drv_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] cnt_q;

  // Count up on inc_i, stop once every bit is set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + One;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_csr_access_driver.sv
// CSR-bus initiator: issues one access per command,
// captures the response and tallies mismatches.
module ibex_csr_access_driver
  import csr_drv_pkg::*;
#(
  parameter int unsigned CntWidth = 16,
  parameter int unsigned IdleGap  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  csr_op_e             cmd_op_i,
  input  logic [11:0]         cmd_addr_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic                cmd_check_i,
  input  logic [31:0]         cmd_exp_rdata_i,
  input  logic [31:0]         cmd_exp_mask_i,
  input  logic                cmd_exp_illegal_i,
  output logic                csr_access_o,
  output csr_op_e             csr_op_o,
  output logic                csr_op_en_o,
  output logic [11:0]         csr_addr_o,
  output logic [31:0]         csr_wdata_o,
  input  logic [31:0]         csr_rdata_i,
  input  logic                illegal_csr_insn_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_illegal_o,
  output logic                rsp_mismatch_o,
  output logic [CntWidth-1:0] num_cmds_o,
  output logic [CntWidth-1:0] num_errors_o,
  output logic                test_passed_o
);

  localparam logic [3:0] GapLoad = 4'(IdleGap);

  drv_state_e   state_q, state_d;
  logic [3:0]   gap_q, gap_d;
  csr_drv_cmd_t cmd_q;
  logic         cmd_ld;
  logic         rsp_cap;
  logic         mism;
  logic         in_access;

  assign in_access = state_q == ACCESS;
  assign mism = rsp_mismatch(cmd_q, csr_rdata_i, illegal_csr_insn_i);

  // Next-state logic for the one-access-in-flight sequencer.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cmd_ld  = 1'b0;
    rsp_cap = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cmd_ld  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rsp_cap = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (GapLoad != 4'd0) begin
            state_d = GAP;
            gap_d   = GapLoad;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command latch and captured response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      gap_q          <= 4'd0;
      cmd_q          <= '0;
      rsp_rdata_o    <= 32'd0;
      rsp_illegal_o  <= 1'b0;
      rsp_mismatch_o <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (cmd_ld) begin
        cmd_q.op          <= cmd_op_i;
        cmd_q.addr        <= cmd_addr_i;
        cmd_q.wdata       <= cmd_wdata_i;
        cmd_q.check       <= cmd_check_i;
        cmd_q.exp_rdata   <= cmd_exp_rdata_i;
        cmd_q.exp_mask    <= cmd_exp_mask_i;
        cmd_q.exp_illegal <= cmd_exp_illegal_i;
      end
      if (rsp_cap) begin
        rsp_rdata_o    <= csr_rdata_i;
        rsp_illegal_o  <= illegal_csr_insn_i;
        rsp_mismatch_o <= mism;
      end
    end
  end

  csr_drv_sat_cnt #(
    .Width (CntWidth)
  ) u_cmd_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rsp_cap),
    .cnt_o (num_cmds_o)
  );

  csr_drv_sat_cnt #(
    .Width (CntWidth)
  ) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rsp_cap & mism),
    .cnt_o (num_errors_o)
  );

  assign cmd_ready_o = (state_q == IDLE) & ~rst_i;
  assign rsp_valid_o = state_q == RESP;

  assign csr_access_o = in_access;
  assign csr_op_o     = in_access ? cmd_q.op : CSR_OP_READ;
  assign csr_op_en_o  = in_access & (cmd_q.op != CSR_OP_READ);
  assign csr_addr_o   = in_access ? cmd_q.addr : 12'd0;
  assign csr_wdata_o  = in_access ? cmd_q.wdata : 32'd0;

  assign test_passed_o = (num_cmds_o != '0) && (num_errors_o == '0);

endmodule

// File: tb/tb_ibex_csr_access_driver.sv
// Directed bench for ibex_csr_access_driver with a
// one-register (mscratch) CSR responder model.
module tb_ibex_csr_access_driver;
  import csr_drv_pkg::*;

  localparam int CW = 2;
  localparam int GW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  csr_op_e       cmd_op = CSR_OP_READ;
  logic [11:0]   cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          cmd_check = 1'b0;
  logic [31:0]   cmd_exp_rdata = '0;
  logic [31:0]   cmd_exp_mask = '0;
  logic          cmd_exp_ill = 1'b0;
  logic          csr_access;
  csr_op_e       csr_op;
  logic          csr_op_en;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_ill;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_ill;
  logic          rsp_mm;
  logic [CW-1:0] num_cmds;
  logic [CW-1:0] num_errs;
  logic          passed;

  int n_chk = 0;
  int n_fail = 0;

  ibex_csr_access_driver #(
    .CntWidth (CW),
    .IdleGap  (GW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_op_i           (cmd_op),
    .cmd_addr_i         (cmd_addr),
    .cmd_wdata_i        (cmd_wdata),
    .cmd_check_i        (cmd_check),
    .cmd_exp_rdata_i    (cmd_exp_rdata),
    .cmd_exp_mask_i     (cmd_exp_mask),
    .cmd_exp_illegal_i  (cmd_exp_ill),
    .csr_access_o       (csr_access),
    .csr_op_o           (csr_op),
    .csr_op_en_o        (csr_op_en),
    .csr_addr_o         (csr_addr),
    .csr_wdata_o        (csr_wdata),
    .csr_rdata_i        (csr_rdata),
    .illegal_csr_insn_i (csr_ill),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_rdata_o        (rsp_rdata),
    .rsp_illegal_o      (rsp_ill),
    .rsp_mismatch_o     (rsp_mm),
    .num_cmds_o         (num_cmds),
    .num_errors_o       (num_errs),
    .test_passed_o      (passed)
  );

  always #5 clk = ~clk;

  // Responder: only mscratch exists; reads return the old value.
  logic [31:0] mscratch = 32'd0;
  assign csr_ill   = csr_addr != 12'h340;
  assign csr_rdata = csr_ill ? 32'd0 : mscratch;

  always @(posedge clk) begin
    if (csr_access && csr_op_en && !csr_ill) begin
      case (csr_op)
        CSR_OP_WRITE: mscratch <= csr_wdata;
        CSR_OP_SET:   mscratch <= mscratch | csr_wdata;
        CSR_OP_CLEAR: mscratch <= mscratch & ~csr_wdata;
        default:      mscratch <= mscratch;
      endcase
    end
  end

  typedef struct {
    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] er;
    logic [31:0] em;
    logic        ei;
    logic [31:0] x_rd;
    logic        x_il;
    logic        x_mm;
    int          x_cmds;
    int          x_errs;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    cmd_op        = v.op;
    cmd_addr      = v.addr;
    cmd_wdata     = v.wd;
    cmd_check     = v.chk;
    cmd_exp_rdata = v.er;
    cmd_exp_mask  = v.em;
    cmd_exp_ill   = v.ei;
    cmd_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    logic pass_x;
    wait_ready();
    drive(v);
    chk($sformatf("v%0d access", i), 32'(csr_access), 32'd1);
    chk($sformatf("v%0d op_en", i), 32'(csr_op_en),
        32'(v.op != CSR_OP_READ));
    chk($sformatf("v%0d addr", i), 32'(csr_addr), 32'(v.addr));
    chk($sformatf("v%0d wdata", i), csr_wdata, v.wd);
    chk($sformatf("v%0d ready_busy", i), 32'(cmd_ready), 32'd0);
    @(negedge clk);
    pass_x = (v.x_cmds != 0) && (v.x_errs == 0);
    chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d rdata", i), rsp_rdata, v.x_rd);
    chk($sformatf("v%0d illegal", i), 32'(rsp_ill), 32'(v.x_il));
    chk($sformatf("v%0d mismatch", i), 32'(rsp_mm), 32'(v.x_mm));
    chk($sformatf("v%0d num_cmds", i), 32'(num_cmds), 32'(v.x_cmds));
    chk($sformatf("v%0d num_errs", i), 32'(num_errs), 32'(v.x_errs));
    chk($sformatf("v%0d passed", i), 32'(passed), 32'(pass_x));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish after 200us");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int g;
    logic [31:0] saved;
    logic [31:0] snap;

    //          op            addr     wdata         chk er            em            ei  x_rd          il mm cmds errs
    vecs[0]  = '{CSR_OP_WRITE, 12'h340, 32'hDEADBEEF, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1, 0};
    vecs[1]  = '{CSR_OP_READ,  12'h340, 32'h0,        1, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 32'hDEADBEEF, 0, 0, 2, 0};
    vecs[2]  = '{CSR_OP_WRITE, 12'h340, 32'hF0,       0, 32'h0,        32'h0,        0, 32'hDEADBEEF, 0, 0, 3, 0};
    vecs[3]  = '{CSR_OP_SET,   12'h340, 32'h0F,       0, 32'h0,        32'h0,        0, 32'hF0,       0, 0, 3, 0};
    vecs[4]  = '{CSR_OP_READ,  12'h340, 32'h0,        1, 32'hFF,       32'hFFFFFFFF, 0, 32'hFF,       0, 0, 3, 0};
    vecs[5]  = '{CSR_OP_CLEAR, 12'h340, 32'h0F,       0, 32'h0,        32'h0,        0, 32'hFF,       0, 0, 3, 0};
    vecs[6]  = '{CSR_OP_READ,  12'h340, 32'h0,        1, 32'hF0,       32'hFFFFFFFF, 0, 32'hF0,       0, 0, 3, 0};
    vecs[7]  = '{CSR_OP_READ,  12'h7FF, 32'h0,        1, 32'h0,        32'h0,        1, 32'h0,        1, 0, 3, 0};
    vecs[8]  = '{CSR_OP_READ,  12'h7FF, 32'h0,        1, 32'h0,        32'h0,        0, 32'h0,        1, 1, 3, 1};
    vecs[9]  = '{CSR_OP_READ,  12'h340, 32'h0,        1, 32'h0F,       32'hFF,       0, 32'hF0,       0, 1, 3, 2};
    vecs[10] = '{CSR_OP_READ,  12'h340, 32'h0,        1, 32'hF5,       32'hF0,       0, 32'hF0,       0, 0, 3, 2};
    vecs[11] = '{CSR_OP_READ,  12'h7FF, 32'h0,        1, 32'h0,        32'h0,        0, 32'h0,        1, 1, 3, 3};
    vecs[12] = '{CSR_OP_READ,  12'h7FF, 32'h0,        1, 32'h0,        32'h0,        0, 32'h0,        1, 1, 3, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst access", 32'(csr_access), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst num_cmds", 32'(num_cmds), 32'd0);
    chk("rst num_errs", 32'(num_errs), 32'd0);
    chk("rst passed", 32'(passed), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Response backpressure, then the idle gap.
    v = '{CSR_OP_WRITE, 12'h340, 32'h12345678, 0, 32'h0, 32'h0, 0,
          32'h0, 0, 0, 0, 0};
    wait_ready();
    drive(v);
    @(negedge clk);
    snap = mscratch;
    chk("bp wrote", snap, 32'h12345678);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d rdata", k), rsp_rdata, 32'hF0);
      chk($sformatf("bp%0d cmd_ready", k), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp%0d access", k), 32'(csr_access), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    g = 0;
    while (!cmd_ready && g < 10) begin
      g++;
      @(negedge clk);
    end
    chk("gap cycles", 32'(g), 32'(GW));
    chk("gap num_cmds", 32'(num_cmds), 32'd1);

    // Reset during a READ access.
    saved = mscratch;
    v = '{CSR_OP_READ, 12'h340, 32'h0, 1, 32'h0, 32'h0, 0,
          32'h0, 0, 0, 0, 0};
    wait_ready();
    drive(v);
    chk("mid access", 32'(csr_access), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid access_off", 32'(csr_access), 32'd0);
    chk("mid op_en", 32'(csr_op_en), 32'd0);
    chk("mid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid rdata", rsp_rdata, 32'd0);
    chk("mid num_cmds", 32'(num_cmds), 32'd0);
    chk("mid passed", 32'(passed), 32'd0);
    chk("mid reg", mscratch, saved);
    rst = 1'b0;
    @(negedge clk);
    chk("post cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post rsp_valid", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
